// File: rtl/ir_load_ctrl_pkg.sv
// Shared definitions for the IR regfile load sequencer: state codes,
// default widths and the memory wait limit.
package ir_load_ctrl_pkg;

  typedef enum logic [3:0] {
    LINIT     = 4'h0,
    LREAD_MEM = 4'h1,
    LWRITE    = 4'h2,
    LWORK     = 4'h3
  } load_state_t;

  localparam int DEF_IRR_WIDTH      = 32;
  localparam int DEF_IR_ADDR_WIDTH  = 4;
  localparam int DEF_MEM_ADDR_WIDTH = 16;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'hFF;

endpackage

// File: rtl/ir_load_addr_gen.sv
// Base/index registers for the load sequencer; produces the memory word
// address (wrapping at the memory address width) and the last-entry flag.
module ir_load_addr_gen
  import ir_load_ctrl_pkg::*;
#(
  parameter int IR_ADDR_WIDTH  = DEF_IR_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      inc,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [IR_ADDR_WIDTH-1:0]  idx,
  output logic                      last
);

  logic [MEM_ADDR_WIDTH-1:0] base_reg;
  logic [IR_ADDR_WIDTH-1:0]  idx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_reg <= '0;
      idx_reg  <= '0;
    end else if (load) begin
      base_reg <= base_addr;
      idx_reg  <= '0;
    end else if (inc) begin
      idx_reg <= idx_reg + IR_ADDR_WIDTH'(1);
    end
  end

  // Sum is kept at the memory address width so it wraps naturally.
  assign mem_addr = base_reg + MEM_ADDR_WIDTH'(idx_reg);
  assign idx      = idx_reg;
  assign last     = &idx_reg;

endmodule

// File: rtl/ir_load_ctrl.sv
// IR regfile load sequencer: copies DEPTH words from memory into the regfile,
// then hands the regfile to the fetch port. Define IR_LOAD_TIMEOUT_EN to add
// a memory wait timeout with a sticky load_err output.
module ir_load_ctrl
  import ir_load_ctrl_pkg::*;
#(
  parameter int IRR_WIDTH      = DEF_IRR_WIDTH,
  parameter int IR_ADDR_WIDTH  = DEF_IR_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic                      reload,
  output logic                      mem_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      mem_ack,
  input  logic [IRR_WIDTH-1:0]      mem_rdata,
  output logic                      rf_mode,
  output logic [IR_ADDR_WIDTH-1:0]  rf_address,
  output logic [IRR_WIDTH-1:0]      rf_data_in,
  input  logic                      fetch_req,
  input  logic [IR_ADDR_WIDTH-1:0]  fetch_addr,
  output logic                      fetch_gnt,
  output logic                      init_finished,
`ifdef IR_LOAD_TIMEOUT_EN
  output logic                      load_err,
`endif
  output logic                      busy
);

  load_state_t               state_reg, state_next;
  logic [IRR_WIDTH-1:0]      buffer_reg;
  logic                      init_finished_reg;
  logic                      addr_load, addr_inc, buf_capture, fin_set, fin_clr;
  logic [MEM_ADDR_WIDTH-1:0] gen_addr;
  logic [IR_ADDR_WIDTH-1:0]  gen_idx;
  logic                      gen_last;

  ir_load_addr_gen #(
    .IR_ADDR_WIDTH (IR_ADDR_WIDTH),
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (addr_load),
    .inc      (addr_inc),
    .base_addr(base_addr),
    .mem_addr (gen_addr),
    .idx      (gen_idx),
    .last     (gen_last)
  );

`ifdef IR_LOAD_TIMEOUT_EN
  logic [7:0] wait_cnt_reg;
  logic       load_err_reg;
  logic       err_set, err_clr;
  logic       wait_expired;

  // Counter idles at zero outside LREAD_MEM, so every read starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (state_reg != LREAD_MEM) begin
      wait_cnt_reg <= '0;
    end else if (!mem_ack) begin
      wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err_reg <= 1'b0;
    end else if (err_set) begin
      load_err_reg <= 1'b1;
    end else if (err_clr) begin
      load_err_reg <= 1'b0;
    end
  end

  assign wait_expired = (wait_cnt_reg == TIMEOUT_LIMIT - 8'd1);
  assign load_err     = load_err_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= LINIT;
      buffer_reg        <= '0;
      init_finished_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (buf_capture) begin
        buffer_reg <= mem_rdata;
      end
      if (fin_set) begin
        init_finished_reg <= 1'b1;
      end else if (fin_clr) begin
        init_finished_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_load   = 1'b0;
    addr_inc    = 1'b0;
    buf_capture = 1'b0;
    fin_set     = 1'b0;
    fin_clr     = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    rf_mode     = 1'b0;
    rf_address  = '0;
    rf_data_in  = '0;
    fetch_gnt   = 1'b0;
    busy        = 1'b0;
`ifdef IR_LOAD_TIMEOUT_EN
    err_set     = 1'b0;
    err_clr     = 1'b0;
`endif
    case (state_reg)
      LINIT: begin
        if (start) begin
          addr_load  = 1'b1;
          state_next = LREAD_MEM;
`ifdef IR_LOAD_TIMEOUT_EN
          err_clr    = 1'b1;
`endif
        end
      end
      LREAD_MEM: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = gen_addr;
        if (mem_ack) begin
          buf_capture = 1'b1;
          state_next  = LWRITE;
        end
`ifdef IR_LOAD_TIMEOUT_EN
        else if (wait_expired) begin
          err_set    = 1'b1;
          state_next = LINIT;
        end
`endif
      end
      LWRITE: begin
        busy       = 1'b1;
        rf_mode    = 1'b1;
        rf_address = gen_idx;
        rf_data_in = buffer_reg;
        if (gen_last) begin
          fin_set    = 1'b1;
          state_next = LWORK;
        end else begin
          addr_inc   = 1'b1;
          state_next = LREAD_MEM;
        end
      end
      LWORK: begin
        rf_address = fetch_addr;
        fetch_gnt  = fetch_req;
        if (reload) begin
          addr_load  = 1'b1;
          fin_clr    = 1'b1;
          state_next = LREAD_MEM;
        end
      end
      default: state_next = LINIT;
    endcase
  end

  assign init_finished = init_finished_reg;

endmodule

// File: tb/tb_ir_load_ctrl.sv
// Directed bench for ir_load_ctrl: a timing model derived from the load
// schedule (3 cycles per entry with 1-cycle memory latency) checked every cycle.
module tb_ir_load_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        reload = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;
  logic        rf_mode;
  logic [3:0]  rf_address;
  logic [31:0] rf_data_in;
  logic        fetch_req = 1'b0;
  logic [3:0]  fetch_addr = '0;
  logic        fetch_gnt;
  logic        init_finished;
  logic        busy;
`ifdef IR_LOAD_TIMEOUT_EN
  logic        load_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ir_load_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .reload       (reload),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .rf_mode      (rf_mode),
    .rf_address   (rf_address),
    .rf_data_in   (rf_data_in),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .init_finished(init_finished),
`ifdef IR_LOAD_TIMEOUT_EN
    .load_err     (load_err),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: acks each request on its second cycle with data = addr ^ A5A5_0000.
  logic ack_en = 1'b1;
  int   req_age = 0;
  always @(posedge clk) begin
    #1;
    if (mem_req && ack_en) begin
      req_age = req_age + 1;
      if (req_age > 1) begin
        mem_ack   = 1'b1;
        mem_rdata = {16'h0000, mem_addr} ^ 32'hA5A5_0000;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end else begin
      req_age   = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
  end

  // Model: phase 0 idle, 1 loading (k counts cycles since load start), 2 working.
  int          m_mode = 0;
  int          m_k = 0;
  logic [15:0] m_base = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_k    <= 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode <= 1; m_k <= 0; m_base <= base_addr; end
        1: if (m_k == 47) m_mode <= 2; else m_k <= m_k + 1;
        default: if (reload) begin m_mode <= 1; m_k <= 0; m_base <= base_addr; end
      endcase
    end
  end

  logic        chk_en = 1'b1;
  int          wr_count = 0;
  int          req_count = 0;
  int          fin_rises = 0;
  logic        prev_req = 1'b0;
  logic        prev_fin = 1'b0;
  logic [31:0] wr_log [16];
  logic [15:0] addr_log [16];

  always @(negedge clk) begin
    logic        e_req, e_mode, e_gnt, e_fin, e_busy;
    logic [15:0] e_addr, ent_addr;
    logic [3:0]  e_rfa;
    logic [31:0] e_rfd;
    int          ent, ph;
    e_req = 0; e_mode = 0; e_gnt = 0; e_fin = 0; e_busy = 0;
    e_addr = '0; e_rfa = '0; e_rfd = '0;
    if (!rst && m_mode == 1) begin
      ent      = m_k / 3;
      ph       = m_k % 3;
      ent_addr = m_base + 16'(ent);
      e_busy   = 1;
      if (ph < 2) begin
        e_req  = 1;
        e_addr = ent_addr;
      end else begin
        e_mode = 1;
        e_rfa  = 4'(ent);
        e_rfd  = {16'h0000, ent_addr} ^ 32'hA5A5_0000;
      end
    end else if (!rst && m_mode == 2) begin
      e_fin = 1;
      e_rfa = fetch_addr;
      e_gnt = fetch_req;
    end
    if (chk_en) begin
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("rf_mode", 32'(rf_mode), 32'(e_mode));
      chk("rf_address", 32'(rf_address), 32'(e_rfa));
      chk("rf_data_in", rf_data_in, e_rfd);
      chk("fetch_gnt", 32'(fetch_gnt), 32'(e_gnt));
      chk("init_finished", 32'(init_finished), 32'(e_fin));
      chk("busy", 32'(busy), 32'(e_busy));
    end
    if (rf_mode) begin
      $display("write idx=%0d data=%h", rf_address, rf_data_in);
      if (wr_count < 16) wr_log[wr_count] = rf_data_in;
      wr_count = wr_count + 1;
    end
    if (mem_req && !prev_req) begin
      if (req_count < 16) addr_log[req_count] = mem_addr;
      req_count = req_count + 1;
    end
    if (init_finished && !prev_fin) fin_rises = fin_rises + 1;
    prev_req = mem_req;
    prev_fin = init_finished;
  end

  task automatic clear_logs();
    wr_count  = 0;
    req_count = 0;
    fin_rises = 0;
  endtask

  task automatic pulse_start(input logic [15:0] b);
    @(posedge clk); #1;
    base_addr = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (init_finished) done = 1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: init_finished got 0 expected 1 within 300 cycles", name);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", 32'(mem_req), 32'h0);
    chk("reset_init_finished", 32'(init_finished), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rf_mode", 32'(rf_mode), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // reload in LINIT is ignored
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    chk("reload_ignored_busy", 32'(busy), 32'h0);

    // Initial load from 0x0100, with fetch requests during the load
    clear_logs();
    pulse_start(16'h0100);
    repeat (4) @(posedge clk);
    #1;
    fetch_req  = 1'b1;
    fetch_addr = 4'h3;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("fetch_during_load_gnt", 32'(fetch_gnt), 32'h0);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    wait_finish("load_0100");
    repeat (5) @(negedge clk);
    chk("load_0100_writes", 32'(wr_count), 32'd16);
    chk("load_0100_fin_rises", 32'(fin_rises), 32'd1);
    chk("load_0100_entry0", wr_log[0], 32'hA5A5_0100);
    chk("load_0100_entry15", wr_log[15], 32'hA5A5_010F);

    // Fetch in LWORK
    @(posedge clk); #1;
    fetch_req  = 1'b1;
    fetch_addr = 4'h7;
    @(negedge clk);
    chk("fetch_gnt", 32'(fetch_gnt), 32'h1);
    chk("fetch_rf_address", 32'(rf_address), 32'h7);
    @(posedge clk); #1;
    fetch_req = 1'b0;

    // Reload to a wrapping base, with a fetch in the same cycle
    clear_logs();
    @(posedge clk); #1;
    base_addr  = 16'hFFF8;
    reload     = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 4'h7;
    @(negedge clk);
    chk("reload_fetch_gnt", 32'(fetch_gnt), 32'h1);
    @(posedge clk); #1;
    reload    = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("reload_init_finished", 32'(init_finished), 32'h0);
    chk("reload_busy", 32'(busy), 32'h1);
    chk("reload_mem_addr", 32'(mem_addr), 32'hFFF8);
    wait_finish("load_fff8");
    @(negedge clk);
    chk("wrap_writes", 32'(wr_count), 32'd16);
    chk("wrap_addr7", 32'(addr_log[7]), 32'hFFFF);
    chk("wrap_addr8", 32'(addr_log[8]), 32'h0000);
    chk("wrap_addr15", 32'(addr_log[15]), 32'h0007);
    chk("wrap_entry8", wr_log[8], 32'hA5A5_0000);

    // Asynchronous reset at entry 5 of a reload
    @(posedge clk); #1;
    base_addr = 16'h0300;
    reload    = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    begin
      bit hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (mem_req && mem_addr == 16'h0305) hit = 1;
      end
      chk("reach_entry5", 32'(hit), 32'h1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'h0);
    chk("async_rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_init_finished", 32'(init_finished), 32'h0);
    chk("async_rst_rf_address", 32'(rf_address), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    pulse_start(16'h0040);
    wait_finish("load_0040");
    @(negedge clk);
    chk("restart_addr0", 32'(addr_log[0]), 32'h0040);
    chk("restart_entry0", wr_log[0], 32'hA5A5_0040);
    chk("restart_writes", 32'(wr_count), 32'd16);

`ifdef IR_LOAD_TIMEOUT_EN
    // Memory never answers: the request must be withdrawn after 255 cycles
    chk_en = 1'b0;
    ack_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start(16'h0500);
    begin
      int  high = 0;
      bit  gone = 0;
      for (int i = 0; i < 400 && !gone; i++) begin
        @(negedge clk);
        if (mem_req) high++;
        else gone = 1;
      end
      chk("timeout_req_cycles", 32'(high), 32'd255);
    end
    @(negedge clk);
    chk("timeout_load_err", 32'(load_err), 32'h1);
    chk("timeout_busy", 32'(busy), 32'h0);
    chk("timeout_init_finished", 32'(init_finished), 32'h0);
    ack_en = 1'b1;
    pulse_start(16'h0600);
    @(negedge clk);
    chk("timeout_err_cleared", 32'(load_err), 32'h0);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ir_load_ctrl.md
Name: ir_load_ctrl

Overview:
- Sequencer for the instruction register file (IR regfile, 2**IR_ADDR_WIDTH entries of IRR_WIDTH bits).
- Copies a block of instruction words from data memory into the regfile, then hands the regfile to the core fetch port.
- Raises init_finished once the regfile holds a valid program.
- Sits between the memory interface, the IR regfile write/address port and the fetch stage.

Parameters:
- IRR_WIDTH, 32, width of one IR regfile entry and of memory read data.
- IR_ADDR_WIDTH, 4, IR regfile address width; depth DEPTH = 2**IR_ADDR_WIDTH.
- MEM_ADDR_WIDTH, 16, memory word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins the initial load, honoured only in LINIT.
- base_addr  in  MEM_ADDR_WIDTH  memory address of entry 0; sampled on an accepted start or reload.
- reload  in  1  one-cycle pulse; re-runs the load, honoured only in LWORK.
- mem_req  out  1  memory read request.
- mem_addr  out  MEM_ADDR_WIDTH  memory read address.
- mem_ack  in  1  read-data-valid strobe for the outstanding request.
- mem_rdata  in  IRR_WIDTH  memory read data, valid with mem_ack.
- rf_mode  out  1  IR regfile write enable.
- rf_address  out  IR_ADDR_WIDTH  IR regfile address.
- rf_data_in  out  IRR_WIDTH  IR regfile write data.
- fetch_req  in  1  core fetch request.
- fetch_addr  in  IR_ADDR_WIDTH  core fetch index.
- fetch_gnt  out  1  fetch accepted this cycle.
- init_finished  out  1  regfile contents valid.
- busy  out  1  load in progress.

Behaviour:
- State codes: LINIT=4'h0, LREAD_MEM=4'h1, LWRITE=4'h2, LWORK=4'h3.
- Reset (asynchronous, any time, including mid-load) forces:
  - state=LINIT, idx=0, word buffer=0;
  - mem_req=0, mem_addr=0, rf_mode=0, rf_address=0, rf_data_in=0;
  - fetch_gnt=0, init_finished=0, busy=0.
- LINIT:
  - Outputs idle.
  - start=1: latch base_addr, idx<=0, go to LREAD_MEM.
  - reload is ignored.
- LREAD_MEM:
  - mem_req=1, mem_addr=base+idx, with the add truncated to MEM_ADDR_WIDTH (wraps at 2**MEM_ADDR_WIDTH).
  - Hold until mem_ack=1. On that edge, capture mem_rdata into the buffer, drop mem_req next cycle, go to LWRITE.
  - No cycle limit unless the optional feature is compiled in.
- LWRITE (exactly 1 cycle):
  - rf_mode=1, rf_address=idx, rf_data_in=buffer.
  - If idx==DEPTH-1: go to LWORK.
  - Else: idx<=idx+1, go to LREAD_MEM.
  - Each entry costs 2 cycles plus memory latency.
- busy=1 in LREAD_MEM and LWRITE.
- init_finished rises on entry to LWORK, registered, first high the cycle after the last LWRITE. It stays high until reset or an accepted reload.
- LWORK:
  - rf_mode=0; rf_address=fetch_addr (combinational pass-through); fetch_gnt=fetch_req.
  - reload=1: latch base_addr, idx<=0, init_finished<=0, go to LREAD_MEM.
  - If fetch_req and reload arrive in the same cycle, the fetch is granted and the reload is taken at the same edge.
- Outside LWORK, fetch_gnt=0. Fetch requests are neither queued nor remembered.
- mem_ack outside LREAD_MEM is ignored.
- start outside LINIT is ignored.
- Only one memory request is ever outstanding.

Optional Feature:
- Macro: IR_LOAD_TIMEOUT_EN.
- Defined:
  - Adds an 8-bit wait counter, cleared on LREAD_MEM entry and incremented each cycle without mem_ack.
  - When the counter reaches 8'hFF: drop mem_req, set the sticky output load_err=1, go to LINIT. init_finished stays 0.
  - load_err clears on reset or the next accepted start.
- Undefined: no counter, no load_err port; LREAD_MEM waits indefinitely.

Decomposition:
- Shared define file holds:
  - state codes LINIT/LREAD_MEM/LWRITE/LWORK;
  - default IRR_WIDTH, IR_ADDR_WIDTH, MEM_ADDR_WIDTH;
  - timeout limit constant.
- One sub-module: ir_load_addr_gen. It holds base/idx registers, produces mem_addr and the last-entry flag, and owns the wrap arithmetic.
- The FSM and output muxing stay in the top.

Test Plan:
- Reset, start with base_addr=16'h0100, mem_ack 1 cycle after each req, mem_rdata=addr^32'hA5A5_0000:
  - 16 writes with rf_address 0..15, data matching;
  - init_finished high exactly once, after write 15.
- base_addr=16'hFFF8 → mem_addr sequence FFF8..FFFF, 0000..0007 (wrap); all 16 entries written.
- In LWORK, fetch_req=1 with fetch_addr=4'h7 → fetch_gnt=1 and rf_address=7 the same cycle.
- During load, fetch_req=1 → fetch_gnt stays 0 and rf_mode pulses unaffected.
- reload with fetch_req in the same cycle in LWORK:
  - that fetch granted;
  - next cycle init_finished=0, busy=1, mem_addr=new base.
- Assert rst at entry 5 while mem_req=1:
  - all outputs 0 immediately (asynchronous);
  - after release, a new start restarts from idx 0.
- With IR_LOAD_TIMEOUT_EN and mem_ack never asserted → mem_req drops after 255 cycles, load_err=1, state LINIT.
